// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard sequencer: FSM encodings,
// register-index width, the control bundle and the load-use decode.
package pipe_hazard_ctrl_pkg;

    localparam int REG_IDX_W = 5;

    localparam logic [0:0] ST_RUN      = 1'b0;
    localparam logic [0:0] ST_MEM_WAIT = 1'b1;

    typedef struct packed {
        logic pc_en;
        logic fd_en;
        logic de_en;
        logic em_en;
        logic mw_en;
        logic fd_flush;
        logic de_flush;
        logic em_flush;
        logic mw_flush;
        logic dmem_req;
    } ctrl_t;

    localparam ctrl_t CTRL_ADVANCE = '{
        pc_en: 1'b1, fd_en: 1'b1, de_en: 1'b1, em_en: 1'b1, mw_en: 1'b1,
        fd_flush: 1'b0, de_flush: 1'b0, em_flush: 1'b0, mw_flush: 1'b0,
        dmem_req: 1'b0
    };

    localparam ctrl_t CTRL_RESET = '{
        pc_en: 1'b0, fd_en: 1'b0, de_en: 1'b0, em_en: 1'b0, mw_en: 1'b0,
        fd_flush: 1'b1, de_flush: 1'b1, em_flush: 1'b1, mw_flush: 1'b1,
        dmem_req: 1'b0
    };

    // r0 is hard-wired zero, so a load targeting it never creates a dependency.
    function automatic logic load_use_hazard(
        input logic                 mem_to_reg,
        input logic [REG_IDX_W-1:0] rw,
        input logic [REG_IDX_W-1:0] rs,
        input logic [REG_IDX_W-1:0] rt,
        input logic                 use_rt
    );
        return mem_to_reg && (rw != '0) && ((rw == rs) || (use_rt && (rw == rt)));
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencer: per-stage enables/flushes from load-use, taken-branch and
// data-memory handshake events; state advances on the same negedge as the datapath.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int STALL_CNT_W = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [REG_IDX_W-1:0]   rs_2,
    input  logic [REG_IDX_W-1:0]   rt_2,
    input  logic                   use_rt_2,
    input  logic [REG_IDX_W-1:0]   rw_3,
    input  logic                   MemtoReg_3,
    input  logic                   branch_taken_3,
    input  logic                   MemRead_4,
    input  logic                   MemWrite_4,
    input  logic                   dmem_ready,
    input  logic                   stall_clr,
    output logic                   pc_en,
    output logic                   fd_en,
    output logic                   de_en,
    output logic                   em_en,
    output logic                   mw_en,
    output logic                   fd_flush,
    output logic                   de_flush,
    output logic                   em_flush,
    output logic                   mw_flush,
    output logic                   dmem_req,
    output logic                   mem_err,
    output logic [STALL_CNT_W-1:0] stall_cnt
);

    localparam int                WAIT_W     = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MEM_TIMEOUT);

    logic [0:0]             r_state;
    logic [0:0]             w_state_nxt;
    logic [WAIT_W-1:0]      r_wait_cnt;
    logic [WAIT_W-1:0]      w_wait_cnt_nxt;
    logic                   r_mem_err;
    logic [STALL_CNT_W-1:0] r_stall_cnt;

    logic  w_mem_acc;
    logic  w_load_use;
    logic  w_freeze;
    logic  w_abort;
    logic  w_req;
    ctrl_t w_ctrl;

    function automatic logic [STALL_CNT_W-1:0] sat_inc(input logic [STALL_CNT_W-1:0] v);
        return (&v) ? v : v + STALL_CNT_W'(1);
    endfunction

    assign w_mem_acc  = MemRead_4 | MemWrite_4;
    assign w_load_use = load_use_hazard(MemtoReg_3, rw_3, rs_2, rt_2, use_rt_2);

    // Memory handshake FSM: decides freeze/abort and the next wait state.
    always_comb begin
        w_state_nxt    = r_state;
        w_wait_cnt_nxt = r_wait_cnt;
        w_freeze       = 1'b0;
        w_abort        = 1'b0;
        w_req          = 1'b0;
        if (r_state == ST_RUN) begin
            if (w_mem_acc) begin
                w_req = 1'b1;
                if (!dmem_ready) begin
                    w_freeze       = 1'b1;
                    w_state_nxt    = ST_MEM_WAIT;
                    w_wait_cnt_nxt = WAIT_W'(1);
                end
            end
        end else begin
            if (dmem_ready) begin
                w_req          = 1'b1;
                w_state_nxt    = ST_RUN;
                w_wait_cnt_nxt = '0;
            end else if (r_wait_cnt < WAIT_LIMIT) begin
                w_req          = 1'b1;
                w_freeze       = 1'b1;
                w_wait_cnt_nxt = r_wait_cnt + WAIT_W'(1);
            end else begin
                w_abort        = 1'b1;
                w_state_nxt    = ST_RUN;
                w_wait_cnt_nxt = '0;
            end
        end
    end

    // Stage controls by priority: reset > freeze/abort > branch > load-use.
    always_comb begin
        w_ctrl          = CTRL_ADVANCE;
        w_ctrl.dmem_req = w_req;
        if (w_abort) begin
            w_ctrl.mw_flush = 1'b1;
        end else if (w_freeze) begin
            w_ctrl.pc_en    = 1'b0;
            w_ctrl.fd_en    = 1'b0;
            w_ctrl.de_en    = 1'b0;
            w_ctrl.em_en    = 1'b0;
            w_ctrl.mw_flush = 1'b1;
        end else if (branch_taken_3) begin
            w_ctrl.fd_flush = 1'b1;
            w_ctrl.de_flush = 1'b1;
        end else if (w_load_use) begin
            w_ctrl.pc_en    = 1'b0;
            w_ctrl.fd_en    = 1'b0;
            w_ctrl.de_flush = 1'b1;
        end
        if (!rst_n) begin
            w_ctrl = CTRL_RESET;
        end
    end

    assign pc_en     = w_ctrl.pc_en;
    assign fd_en     = w_ctrl.fd_en;
    assign de_en     = w_ctrl.de_en;
    assign em_en     = w_ctrl.em_en;
    assign mw_en     = w_ctrl.mw_en;
    assign fd_flush  = w_ctrl.fd_flush;
    assign de_flush  = w_ctrl.de_flush;
    assign em_flush  = w_ctrl.em_flush;
    assign mw_flush  = w_ctrl.mw_flush;
    assign dmem_req  = w_ctrl.dmem_req;
    assign mem_err   = r_mem_err;
    assign stall_cnt = r_stall_cnt;

    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_RUN;
            r_wait_cnt  <= '0;
            r_mem_err   <= 1'b0;
            r_stall_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_wait_cnt <= w_wait_cnt_nxt;
            if (w_abort) begin
                r_mem_err <= 1'b1;
            end
            if (stall_clr) begin
                r_stall_cnt <= '0;
            end else if (!w_ctrl.pc_en) begin
                r_stall_cnt <= sat_inc(r_stall_cnt);
            end
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed scenarios plus random
// traffic, compared against a behavioural model of the sequencing rules.
module tb_pipe_hazard_ctrl;

    localparam int MEM_TIMEOUT = 16;
    localparam int STALL_CNT_W = 6;
    localparam int STALL_MAX   = (1 << STALL_CNT_W) - 1;

    logic       clk;
    logic       rst_n;
    logic [4:0] rs_2, rt_2, rw_3;
    logic       use_rt_2, MemtoReg_3, branch_taken_3;
    logic       MemRead_4, MemWrite_4, dmem_ready, stall_clr;
    logic       pc_en, fd_en, de_en, em_en, mw_en;
    logic       fd_flush, de_flush, em_flush, mw_flush;
    logic       dmem_req, mem_err;
    logic [STALL_CNT_W-1:0] stall_cnt;
    logic [9:0] dut_ctrl;

    int n_vec = 0;
    int n_err = 0;

    // Behavioural model: an access is outstanding, how long it has waited,
    // sticky error, and the stall count.
    bit         m_pending;
    int         m_waited;
    bit         m_err;
    int         m_stall;
    logic [9:0] exp_ctrl;

    pipe_hazard_ctrl #(
        .MEM_TIMEOUT(MEM_TIMEOUT),
        .STALL_CNT_W(STALL_CNT_W)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .rs_2(rs_2), .rt_2(rt_2), .use_rt_2(use_rt_2), .rw_3(rw_3),
        .MemtoReg_3(MemtoReg_3), .branch_taken_3(branch_taken_3),
        .MemRead_4(MemRead_4), .MemWrite_4(MemWrite_4),
        .dmem_ready(dmem_ready), .stall_clr(stall_clr),
        .pc_en(pc_en), .fd_en(fd_en), .de_en(de_en), .em_en(em_en), .mw_en(mw_en),
        .fd_flush(fd_flush), .de_flush(de_flush), .em_flush(em_flush), .mw_flush(mw_flush),
        .dmem_req(dmem_req), .mem_err(mem_err), .stall_cnt(stall_cnt)
    );

    assign dut_ctrl = {pc_en, fd_en, de_en, em_en, mw_en,
                       fd_flush, de_flush, em_flush, mw_flush, dmem_req};

    initial begin
        clk = 1'b1;
        forever #5 clk = ~clk;
    end

    // Expected {pc,fd,de,em,mw enables, fd,de,em,mw flushes, dmem_req}.
    function automatic logic [9:0] model_ctrl();
        bit acc, hazard, busy;
        acc    = (MemRead_4 | MemWrite_4);
        hazard = MemtoReg_3 && (rw_3 != 5'd0) &&
                 ((rw_3 == rs_2) || (use_rt_2 && (rw_3 == rt_2)));
        busy   = m_pending || acc;
        if (!rst_n) return 10'b00000_1111_0;
        if (m_pending && !dmem_ready && m_waited >= MEM_TIMEOUT) return 10'b11111_0001_0;
        if (busy && !dmem_ready) return 10'b00001_0001_1;
        if (branch_taken_3) return {5'b11111, 4'b1100, busy};
        if (hazard) return {5'b00111, 4'b0100, busy};
        return {5'b11111, 4'b0000, busy};
    endfunction

    task automatic model_reset();
        m_pending = 0;
        m_waited  = 0;
        m_err     = 0;
        m_stall   = 0;
    endtask

    task automatic model_step();
        logic [9:0] e;
        e = model_ctrl();
        if (!rst_n) begin
            model_reset();
        end else begin
            if (stall_clr) m_stall = 0;
            else if (!e[9] && m_stall < STALL_MAX) m_stall++;
            if (m_pending && !dmem_ready && m_waited >= MEM_TIMEOUT) begin
                m_err = 1; m_pending = 0; m_waited = 0;
            end else if ((m_pending || MemRead_4 || MemWrite_4) && !dmem_ready) begin
                m_pending = 1; m_waited++;
            end else begin
                m_pending = 0; m_waited = 0;
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        model_step();
        #1;
    endtask

    task automatic set_in(input logic [4:0] rs, input logic [4:0] rt, input logic urt,
                          input logic [4:0] rw, input logic mtr, input logic br,
                          input logic mr, input logic mw, input logic rdy, input logic clr);
        rs_2 = rs; rt_2 = rt; use_rt_2 = urt; rw_3 = rw; MemtoReg_3 = mtr;
        branch_taken_3 = br; MemRead_4 = mr; MemWrite_4 = mw; dmem_ready = rdy; stall_clr = clr;
        #1;
        exp_ctrl = model_ctrl();
    endtask

    task automatic rand_in();
        set_in(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom),
               5'($urandom_range(0, 3)), 1'($urandom_range(0, 2) == 0),
               1'($urandom_range(0, 5) == 0), 1'($urandom_range(0, 3) == 0),
               1'($urandom_range(0, 5) == 0), 1'($urandom_range(0, 2) != 0),
               1'($urandom_range(0, 30) == 0));
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            rand_in();
            n_vec++;
            if (dut_ctrl !== 10'b00000_1111_0) begin
                n_err++; $display("FAIL reset_ctrl: got %b want %b", dut_ctrl, 10'b00000_1111_0);
            end
            n_vec++;
            if ({mem_err, stall_cnt} !== '0) begin
                n_err++; $display("FAIL reset_regs: got err=%b cnt=%0d want 0/0", mem_err, stall_cnt);
            end
            tick();
        end
        rst_n = 1'b1;
    endtask

    task automatic test_load_use();
        logic [4:0] rs [5] = '{5'd8, 5'd8, 5'd0, 5'd3, 5'd3};
        logic [4:0] rt [5] = '{5'd0, 5'd0, 5'd0, 5'd5, 5'd5};
        logic       ur [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        logic [4:0] rw [5] = '{5'd8, 5'd8, 5'd0, 5'd5, 5'd5};
        logic       lw [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        for (int i = 0; i < 5; i++) begin
            set_in(rs[i], rt[i], ur[i], rw[i], lw[i], 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
            n_vec++;
            if (dut_ctrl !== exp_ctrl) begin
                n_err++; $display("FAIL load_use[%0d]: got %b want %b", i, dut_ctrl, exp_ctrl);
            end
            tick();
        end
    endtask

    task automatic test_mem_wait();
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        tick();
        for (int i = 0; i < 4; i++) begin
            set_in(0, 0, 0, 0, 0, 0, 1'b1, 1'b0, (i == 3), 1'b0);
            n_vec++;
            if (dut_ctrl !== exp_ctrl) begin
                n_err++; $display("FAIL mem_wait[%0d]: got %b want %b", i, dut_ctrl, exp_ctrl);
            end
            tick();
        end
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        n_vec++;
        if (stall_cnt !== STALL_CNT_W'(3) || stall_cnt !== STALL_CNT_W'(m_stall)) begin
            n_err++; $display("FAIL mem_wait_stalls: got %0d want 3", stall_cnt);
        end
        tick();
    endtask

    task automatic test_branch();
        logic mr [3] = '{1'b0, 1'b1, 1'b1};
        logic rd [3] = '{1'b1, 1'b0, 1'b1};
        for (int i = 0; i < 3; i++) begin
            set_in(5'd8, 5'd0, 1'b0, 5'd8, 1'b1, 1'b1, mr[i], 1'b0, rd[i], 1'b0);
            n_vec++;
            if (dut_ctrl !== exp_ctrl) begin
                n_err++; $display("FAIL branch[%0d]: got %b want %b", i, dut_ctrl, exp_ctrl);
            end
            tick();
        end
    endtask

    task automatic test_timeout();
        for (int i = 0; i <= MEM_TIMEOUT; i++) begin
            set_in(0, 0, 0, 0, 0, 0, 1'b1, 1'b0, 1'b0, 1'b0);
            n_vec++;
            if (dut_ctrl !== exp_ctrl) begin
                n_err++; $display("FAIL timeout[%0d]: got %b want %b", i, dut_ctrl, exp_ctrl);
            end
            if (i == MEM_TIMEOUT) begin
                n_vec++;
                if (dmem_req !== 1'b0 || mw_flush !== 1'b1 || pc_en !== 1'b1) begin
                    n_err++; $display("FAIL timeout_abort: got req=%b mwf=%b pc=%b want 0 1 1",
                                      dmem_req, mw_flush, pc_en);
                end
            end
            tick();
        end
        for (int i = 0; i < 3; i++) begin
            set_in(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
            n_vec++;
            if (mem_err !== 1'b1 || dut_ctrl !== exp_ctrl) begin
                n_err++; $display("FAIL timeout_err[%0d]: got err=%b ctrl=%b want 1 %b",
                                  i, mem_err, dut_ctrl, exp_ctrl);
            end
            tick();
        end
    endtask

    task automatic test_stall_sat();
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        tick();
        for (int i = 0; i < STALL_MAX + 6; i++) begin
            set_in(5'd4, 5'd0, 1'b0, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
            tick();
        end
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        n_vec++;
        if (stall_cnt !== STALL_CNT_W'(STALL_MAX) || stall_cnt !== STALL_CNT_W'(m_stall)) begin
            n_err++; $display("FAIL stall_sat: got %0d want %0d", stall_cnt, STALL_MAX);
        end
        set_in(5'd4, 5'd0, 1'b0, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        tick();
        n_vec++;
        if (stall_cnt !== '0) begin
            n_err++; $display("FAIL stall_clr_wins: got %0d want 0", stall_cnt);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            rand_in();
            n_vec++;
            if (dut_ctrl !== exp_ctrl) begin
                n_err++; $display("FAIL rand_ctrl[%0d]: got %b want %b", i, dut_ctrl, exp_ctrl);
            end
            n_vec++;
            if ({mem_err, stall_cnt} !== {m_err, STALL_CNT_W'(m_stall)}) begin
                n_err++; $display("FAIL rand_regs[%0d]: got err=%b cnt=%0d want err=%b cnt=%0d",
                                  i, mem_err, stall_cnt, m_err, m_stall);
            end
            tick();
        end
    endtask

    task automatic test_reset_mid_wait();
        for (int i = 0; i < 2; i++) begin
            set_in(0, 0, 0, 0, 0, 0, 1'b1, 1'b0, 1'b0, 1'b0);
            tick();
        end
        set_in(0, 0, 0, 0, 0, 0, 1'b1, 1'b0, 1'b0, 1'b0);
        n_vec++;
        if (dut_ctrl !== exp_ctrl || stall_cnt !== STALL_CNT_W'(m_stall) || m_stall == 0) begin
            n_err++; $display("FAIL pre_reset_wait: got %b cnt=%0d want %b cnt=%0d",
                              dut_ctrl, stall_cnt, exp_ctrl, m_stall);
        end
        rst_n = 1'b0;
        #1;
        model_reset();
        n_vec++;
        if (dut_ctrl !== 10'b00000_1111_0 || stall_cnt !== '0 || mem_err !== 1'b0) begin
            n_err++; $display("FAIL async_reset: got %b cnt=%0d err=%b want 0000011110 0 0",
                              dut_ctrl, stall_cnt, mem_err);
        end
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
            n_vec++;
            if (dut_ctrl !== 10'b11111_0000_0 || dut_ctrl !== exp_ctrl) begin
                n_err++; $display("FAIL post_reset_run[%0d]: got %b want 1111100000", i, dut_ctrl);
            end
            tick();
        end
    endtask

    initial begin
        rst_n = 1'b1;
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        test_reset();
        test_load_use();
        test_mem_wait();
        test_branch();
        test_timeout();
        test_stall_sat();
        test_random();
        test_reset_mid_wait();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
